// File: rtl/pokey_kbd_pkg.sv
// Shared types and default parameters for the POKEY keyboard scan engine.
package pokey_kbd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StHeld,
    StRelease
  } kbd_state_t;

  localparam int unsigned SCAN_DIV_DEFAULT   = 114;
  localparam logic [5:0]  BREAK_ADDR_DEFAULT = 6'h10;
  localparam logic [5:0]  SHIFT_ADDR_DEFAULT = 6'h20;
  localparam logic [5:0]  CTRL_ADDR_DEFAULT  = 6'h30;

endpackage

// File: rtl/pokey_scan_prescaler.sv
// Scan-rate divider: counts 0..Div-1 and flags the last cycle of each window with step.
module pokey_scan_prescaler
  import pokey_kbd_pkg::*;
#(
  parameter int unsigned Div = SCAN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic step
);

  localparam int unsigned W = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [W-1:0] Last = W'(Div - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == Last)) begin
      cnt_d = '0;
    end
    step = !clr && (cnt_q == Last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pokey_key_scanner.sv
// POKEY keyboard scanner: walks the scan address, debounces key presses and
// publishes KBCODE, SKSTAT key bits and keyboard/break interrupt pulses.
module pokey_key_scanner
  import pokey_kbd_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = SCAN_DIV_DEFAULT,
  parameter logic [5:0]  BREAK_ADDR = BREAK_ADDR_DEFAULT,
  parameter logic [5:0]  SHIFT_ADDR = SHIFT_ADDR_DEFAULT,
  parameter logic [5:0]  CTRL_ADDR  = CTRL_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       debounce_en,
  input  logic       kr1_L,
  input  logic       kr2_L,
  output logic [5:0] key_scan_L,
  output logic [7:0] kbcode,
  output logic       key_irq,
  output logic       break_irq,
  output logic       keydown_L,
  output logic       shift_L
);

  logic       step;
  logic       key_dn, mod_dn, accept;
  kbd_state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] cmp_q, cmp_d;
  logic [7:0] kbcode_q, kbcode_d;
  logic       key_irq_q, key_irq_d;
  logic       break_irq_q, break_irq_d;
  logic       brk_prev_q, brk_prev_d;
  logic       keydown_q, keydown_d;
  logic       shift_q, shift_d;
  logic       ctrl_q, ctrl_d;

  pokey_scan_prescaler #(
    .Div (SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (~scan_en),
    .step (step)
  );

  assign key_dn = ~kr1_L;
  assign mod_dn = ~kr2_L;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmp_d       = cmp_q;
    kbcode_d    = kbcode_q;
    key_irq_d   = 1'b0;
    break_irq_d = 1'b0;
    brk_prev_d  = brk_prev_q;
    keydown_d   = keydown_q;
    shift_d     = shift_q;
    ctrl_d      = ctrl_q;
    accept      = 1'b0;

    if (!scan_en) begin
      // kbcode is deliberately retained across a scan disable.
      cnt_d      = '0;
      state_d    = StIdle;
      brk_prev_d = 1'b0;
      keydown_d  = 1'b0;
      shift_d    = 1'b0;
      ctrl_d     = 1'b0;
    end else if (step) begin
      cnt_d = cnt_q + 6'd1;

      if (cnt_q == SHIFT_ADDR) shift_d = mod_dn;
      if (cnt_q == CTRL_ADDR)  ctrl_d  = mod_dn;
      if (cnt_q == BREAK_ADDR) begin
        brk_prev_d  = mod_dn;
        break_irq_d = mod_dn && !brk_prev_q;
      end

      case (state_q)
        StIdle: begin
          if (key_dn) begin
            cmp_d = cnt_q;
            if (debounce_en) begin
              state_d = StCheck;
            end else begin
              state_d = StHeld;
              accept  = 1'b1;
            end
          end
        end
        StCheck: begin
          if (cnt_q == cmp_q) begin
            if (key_dn) begin
              state_d = StHeld;
              accept  = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StHeld: begin
          if ((cnt_q == cmp_q) && !key_dn) begin
            state_d = debounce_en ? StRelease : StIdle;
          end
        end
        StRelease: begin
          if (cnt_q == cmp_q) begin
            state_d = key_dn ? StHeld : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (accept) begin
        kbcode_d  = {ctrl_q, shift_q, cmp_d};
        key_irq_d = 1'b1;
        keydown_d = 1'b1;
      end
      if ((state_d == StIdle) && (state_q != StIdle)) begin
        keydown_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cmp_q       <= '0;
      kbcode_q    <= '0;
      key_irq_q   <= 1'b0;
      break_irq_q <= 1'b0;
      brk_prev_q  <= 1'b0;
      keydown_q   <= 1'b0;
      shift_q     <= 1'b0;
      ctrl_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmp_q       <= cmp_d;
      kbcode_q    <= kbcode_d;
      key_irq_q   <= key_irq_d;
      break_irq_q <= break_irq_d;
      brk_prev_q  <= brk_prev_d;
      keydown_q   <= keydown_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign key_scan_L = ~cnt_q;
  assign kbcode     = kbcode_q;
  assign key_irq    = key_irq_q;
  assign break_irq  = break_irq_q;
  assign keydown_L  = ~keydown_q;
  assign shift_L    = ~shift_q;

endmodule

// File: tb/tb_pokey_key_scanner.sv
// Directed bench for pokey_key_scanner with a small scan divider and a
// combinational keyboard matrix model driven from the scan address.
module tb_pokey_key_scanner;

  localparam int unsigned DIV  = 4;
  localparam int unsigned SCAN = 64 * DIV;

  logic       clk = 1'b0;
  logic       rst, scan_en, debounce_en;
  logic       kr1_L, kr2_L;
  logic [5:0] key_scan_L;
  logic [7:0] kbcode;
  logic       key_irq, break_irq, keydown_L, shift_L;

  logic [63:0] keys, mods;
  logic [5:0]  scan_addr;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int kirq_cnt = 0;
  int kirq_cyc = -1;
  int birq_cnt = 0;
  int c0;

  logic [5:0] exp_addr, exp_scan;

  pokey_key_scanner #(
    .SCAN_DIV   (DIV),
    .BREAK_ADDR (6'h10),
    .SHIFT_ADDR (6'h20),
    .CTRL_ADDR  (6'h30)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_en     (scan_en),
    .debounce_en (debounce_en),
    .kr1_L       (kr1_L),
    .kr2_L       (kr2_L),
    .key_scan_L  (key_scan_L),
    .kbcode      (kbcode),
    .key_irq     (key_irq),
    .break_irq   (break_irq),
    .keydown_L   (keydown_L),
    .shift_L     (shift_L)
  );

  always #5 clk = ~clk;

  assign scan_addr = ~key_scan_L;
  assign kr1_L     = ~keys[scan_addr];
  assign kr2_L     = ~mods[scan_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n cycles, sampling on the falling edge and tallying IRQ pulses.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (key_irq) begin
        kirq_cnt++;
        kirq_cyc = cyc;
      end
      if (break_irq) birq_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    scan_en = 1'b1;
    debounce_en = 1'b1;
    keys = '0;
    mods = '0;
    run(2);

    chk("rst_scan", key_scan_L, 6'h3F);
    chk("rst_kbcode", kbcode, 8'h00);
    chk("rst_key_irq", key_irq, 1'b0);
    chk("rst_break_irq", break_irq, 1'b0);
    chk("rst_keydown", keydown_L, 1'b1);
    chk("rst_shift", shift_L, 1'b1);
    rst = 1'b0;
    kirq_cnt = 0;
    birq_cnt = 0;

    // 1: idle walk of every scan address
    for (int k = 0; k < int'(SCAN); k++) begin
      exp_addr = 6'(k / int'(DIV));
      exp_scan = ~exp_addr;
      chk("walk", key_scan_L, exp_scan);
      run(1);
    end
    chk("walk_wrap", key_scan_L, 6'h3F);
    chk("walk_no_irq", kirq_cnt + birq_cnt, 0);
    chk("walk_keydown", keydown_L, 1'b1);

    // 2: debounced press of 0x12 held two scans
    c0 = cyc;
    keys[6'h12] = 1'b1;
    run(2 * SCAN);
    chk("t2_irq_cnt", kirq_cnt, 1);
    chk("t2_irq_cyc", kirq_cyc, c0 + 19 * DIV + SCAN);
    chk("t2_kbcode", kbcode, 8'h12);
    chk("t2_keydown", keydown_L, 1'b0);
    keys[6'h12] = 1'b0;
    run(2 * SCAN);
    chk("t2_release", keydown_L, 1'b1);
    chk("t2_irq_after_rel", kirq_cnt, 1);

    // 3: single-pass glitch rejected, then shifted key 0x05
    keys[6'h12] = 1'b1;
    run(SCAN);
    keys[6'h12] = 1'b0;
    run(SCAN);
    chk("t3_glitch_irq", kirq_cnt, 1);
    chk("t3_glitch_keydown", keydown_L, 1'b1);
    c0 = cyc;
    mods[6'h20] = 1'b1;
    keys[6'h05] = 1'b1;
    run(2 * SCAN);
    chk("t3_irq_cnt", kirq_cnt, 2);
    chk("t3_irq_cyc", kirq_cyc, c0 + 6 * DIV + SCAN);
    chk("t3_kbcode", kbcode, 8'h45);
    chk("t3_shift", shift_L, 1'b0);

    // 4: second key while 0x05 held is ignored until 0x05 releases
    keys = '0;
    mods = '0;
    run(2 * SCAN);
    chk("t4_shift_rel", shift_L, 1'b1);
    keys[6'h05] = 1'b1;
    run(2 * SCAN);
    chk("t4_kbcode05", kbcode, 8'h05);
    chk("t4_irq05", kirq_cnt, 3);
    keys[6'h20] = 1'b1;
    run(2 * SCAN);
    chk("t4_no_new_irq", kirq_cnt, 3);
    chk("t4_kbcode_hold", kbcode, 8'h05);
    chk("t4_keydown", keydown_L, 1'b0);
    keys[6'h05] = 1'b0;
    run(3 * SCAN);
    chk("t4_irq20", kirq_cnt, 4);
    chk("t4_kbcode20", kbcode, 8'h20);

    // 5: BREAK held three scans (CONTROL also held), then non-debounced key
    keys = '0;
    run(2 * SCAN);
    chk("t5_pre_break", birq_cnt, 0);
    mods[6'h10] = 1'b1;
    mods[6'h30] = 1'b1;
    run(3 * SCAN);
    chk("t5_break_cnt", birq_cnt, 1);
    mods[6'h10] = 1'b0;
    debounce_en = 1'b0;
    c0 = cyc;
    keys[6'h0A] = 1'b1;
    run(SCAN);
    chk("t5_irq_cnt", kirq_cnt, 5);
    chk("t5_irq_cyc", kirq_cyc, c0 + 11 * DIV);
    chk("t5_kbcode", kbcode, 8'h8A);
    chk("t5_keydown", keydown_L, 1'b0);

    // 6: scan disable while held, then mid-scan reset
    run(10);
    scan_en = 1'b0;
    run(1);
    chk("t6_keydown", keydown_L, 1'b1);
    chk("t6_scan", key_scan_L, 6'h3F);
    chk("t6_kbcode", kbcode, 8'h8A);
    chk("t6_shift", shift_L, 1'b1);
    run(20);
    chk("t6_no_irq", kirq_cnt, 5);
    scan_en = 1'b1;
    run(7 * DIV + 2);
    chk("t6_mid_scan", key_scan_L, 6'h38);
    rst = 1'b1;
    run(1);
    chk("t6_rst_scan", key_scan_L, 6'h3F);
    chk("t6_rst_kbcode", kbcode, 8'h00);
    chk("t6_rst_keydown", keydown_L, 1'b1);
    chk("t6_rst_shift", shift_L, 1'b1);
    chk("t6_rst_irqs", {key_irq, break_irq}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pokey_key_scanner.md
# pokey_key_scanner

Keyboard scan engine for the POKEY. It drives the 6-bit active-low scan address onto the controller interface and samples the returned `kr1_L` (key) and `kr2_L` (modifier/break) responses. It debounces key presses with a two-pass compare state machine and publishes `KBCODE`, the SKSTAT key bits and the keyboard/break interrupt requests to the POKEY register block. It sits directly upstream of the controller interface, since it produces `key_scan_L`, and directly downstream of it, since it consumes `kr1_L`/`kr2_L`.

## Interface
Parameters:
- `SCAN_DIV`, default 114: `clk` cycles per scan step, ≈15.7 kHz at 1.79 MHz.
- `BREAK_ADDR`, default 6'h10: scan address at which `kr2_L` reports BREAK.
- `SHIFT_ADDR`, default 6'h20: scan address at which `kr2_L` reports SHIFT.
- `CTRL_ADDR`, default 6'h30: scan address at which `kr2_L` reports CONTROL.

Ports:
- `clk`, in, 1: system clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous, active-high reset.
- `scan_en`, in, 1: SKCTL bit 1, keyboard scan enable.
- `debounce_en`, in, 1: SKCTL bit 0; 1 selects two-pass confirmation.
- `kr1_L`, in, 1: key response, low while the addressed key is pressed.
- `kr2_L`, in, 1: modifier response, low while the addressed modifier is pressed.
- `key_scan_L`, out, 6: scan address, bitwise inverted counter.
- `kbcode`, out, 8: {ctrl, shift, key[5:0]}.
- `key_irq`, out, 1: one-cycle pulse when a new key is accepted.
- `break_irq`, out, 1: one-cycle pulse when BREAK press is detected.
- `keydown_L`, out, 1: SKSTAT bit 2, low while the accepted key is held.
- `shift_L`, out, 1: SKSTAT bit 3, low while SHIFT is held.

## Operation
- Divider: counts 0..SCAN_DIV-1. `step` is asserted in the cycle the divider equals SCAN_DIV-1.
- On `step`:
  - `kr1_L`/`kr2_L` are sampled for the current address.
  - The FSM and modifier flags update.
  - Then the counter increments, wrapping 63→0.
- `key_scan_L = ~counter`.
- Modifiers:
  - At SHIFT_ADDR and CTRL_ADDR, the sampled `kr2_L` updates the `shift` and `ctrl` flags respectively.
  - `shift_L = ~shift`.
  - At BREAK_ADDR, a low sample where the previous BREAK_ADDR sample was high pulses `break_irq`.
- FSM states, with `cmp` = latched 6-bit address:
  - IDLE: key low at any address → `cmp` := addr. If `debounce_en`=1, go to CHECK. If `debounce_en`=0, go directly to HELD and accept.
  - CHECK: at addr==`cmp`, key low → HELD and accept. Key high → IDLE. Other addresses are ignored.
  - HELD: at addr==`cmp`, key high → if `debounce_en`=1, RELEASE; else IDLE. Key low → stay. Other keys are ignored.
  - RELEASE: at addr==`cmp`, key high → IDLE. Key low → HELD with no new accept.
- Accept:
  - `kbcode` := {ctrl, shift, cmp}.
  - `key_irq` pulses for 1 cycle.
  - `keydown_L` goes low.
- `keydown_L` returns high on entry to IDLE.
- `scan_en`=0:
  - Divider, counter and edge history are cleared; FSM goes to IDLE.
  - `keydown_L`=1, `shift_L`=1.
  - `kbcode` is retained.
  - No IRQ pulses are produced.
- A `debounce_en` change takes effect at the next `step`.

## Timing
- Reset values:
  - Divider = 0, counter = 0, so `key_scan_L`=6'h3F.
  - FSM = IDLE, `cmp` = 0.
  - `kbcode`=8'h00.
  - `key_irq`=0, `break_irq`=0.
  - `keydown_L`=1, `shift_L`=1.
- Each address is held for SCAN_DIV cycles. Responses are sampled in the last cycle of that window.
- Full scan period = 64·SCAN_DIV cycles.
- Registered outputs update the cycle after `step`. `key_irq` and `break_irq` are high for exactly that one cycle.
- Accept latency from first detection:
  - `debounce_en`=1: one full scan, 64·SCAN_DIV cycles.
  - `debounce_en`=0: 0 scans.
- `rst` mid-scan overrides everything on the next edge. A pending accept is dropped.
- `kr1_L`/`kr2_L` are synchronous to `clk` via the combinational controller interface. No synchronizer is needed here.

## Structure
- Package `pokey_kbd_pkg` holds:
  - `kbd_state_t` enum: IDLE, CHECK, HELD, RELEASE.
  - Default BREAK/SHIFT/CTRL addresses.
  - `SCAN_DIV_DEFAULT`.
- Sub-module `pokey_scan_prescaler`: parameterised divider with synchronous clear. Outputs `step`.
- All other logic lives in `pokey_key_scanner`: counter, FSM, modifier flags, output registers.

## Test plan
1. Reset, `scan_en`=1, no keys → `key_scan_L` walks 3F,3E,…,00,3F, each held SCAN_DIV cycles. No IRQs. `keydown_L`=1.
2. `debounce_en`=1, key at addr 6'h12 held two scans → exactly one `key_irq`, one scan after detection. `kbcode`=8'h12. `keydown_L`=0. Release for two scans → `keydown_L`=1.
3. `debounce_en`=1, key at 6'h12 low for a single pass → no `key_irq`, FSM back to IDLE. Then SHIFT held with key 6'h05 → `kbcode`=8'h45, `shift_L`=0.
4. Key 6'h05 HELD, second key 6'h20 pressed → no new `key_irq`. `kbcode` stays 8'h05 until 6'h05 is released and 6'h20 is re-detected.
5. `kr2_L` low at BREAK_ADDR for 3 scans → exactly one `break_irq`. `debounce_en`=0 key press → `key_irq` in the same scan as detection.
6. `scan_en` dropped while HELD → `keydown_L`=1, `key_scan_L`=6'h3F, `kbcode` unchanged. Assert `rst` mid-scan → all reset values on the next cycle.
